// File: rtl/step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : step_sequencer
// Brief    : Issues one UART-supplied instruction plus NOP fill to the core,
//            then streams a 1024-bit register-file snapshot out byte-wise.
//            Optional macro STEP_SEQ_CHECKSUM_EN appends an XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module step_sequencer #(
    parameter int          FLUSH_CYCLES = 5,
    parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inst_valid,
    input  logic [31:0]   inst_data,
    output logic          inst_ready,
    output logic          proc_en,
    output logic [31:0]   inst_out,
    input  logic [1023:0] regfile,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic [15:0]   step_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_FLUSH  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_SNAP   = 3'd4;
    localparam logic [2:0] S_SEND   = 3'd5;

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [6:0] c_LAST_IDX   = 7'd127;

    logic [2:0]    r_state;
    logic [3:0]    r_cnt;
    logic [6:0]    r_idx;
    logic [1023:0] r_snap;
    logic [6:0]    w_idx_nxt;
    logic [7:0]    w_byte_nxt;

`ifdef STEP_SEQ_CHECKSUM_EN
    logic [7:0]    r_csum;
    logic          r_csum_phase;
`endif

    assign w_idx_nxt  = r_idx + 7'd1;
    assign w_byte_nxt = r_snap[{w_idx_nxt, 3'b000} +: 8];

    // Snapshot is only meaningful after SNAP, so it carries no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_SNAP) begin
            r_snap <= regfile;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= 7'd0;
            inst_ready   <= 1'b1;
            proc_en      <= 1'b0;
            inst_out     <= NOP_WORD;
            tx_valid     <= 1'b0;
            tx_data      <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            step_count   <= 16'd0;
`ifdef STEP_SEQ_CHECKSUM_EN
            r_csum       <= 8'd0;
            r_csum_phase <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inst_valid && inst_ready) begin
                        inst_out   <= inst_data;
                        proc_en    <= 1'b1;
                        inst_ready <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    inst_out <= NOP_WORD;
                    r_cnt    <= c_FLUSH_LOAD;
                    r_state  <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_cnt == 4'd0) begin
                        proc_en <= 1'b0;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_SETTLE: begin
                    r_state <= S_SNAP;
                end
                S_SNAP: begin
                    // First byte comes straight from the port; r_snap loads on the same edge.
                    r_idx    <= 7'd0;
                    tx_data  <= regfile[7:0];
                    tx_valid <= 1'b1;
                    r_state  <= S_SEND;
`ifdef STEP_SEQ_CHECKSUM_EN
                    r_csum       <= 8'd0;
                    r_csum_phase <= 1'b0;
`endif
                end
                S_SEND: begin
                    if (tx_ready) begin
`ifdef STEP_SEQ_CHECKSUM_EN
                        if (r_csum_phase) begin
                            tx_valid   <= 1'b0;
                            done       <= 1'b1;
                            step_count <= step_count + 16'd1;
                            busy       <= 1'b0;
                            inst_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else if (r_idx == c_LAST_IDX) begin
                            tx_data      <= r_csum ^ tx_data;
                            r_csum_phase <= 1'b1;
                        end else begin
                            r_csum  <= r_csum ^ tx_data;
                            r_idx   <= w_idx_nxt;
                            tx_data <= w_byte_nxt;
                        end
`else
                        if (r_idx == c_LAST_IDX) begin
                            tx_valid   <= 1'b0;
                            done       <= 1'b1;
                            step_count <= step_count + 16'd1;
                            busy       <= 1'b0;
                            inst_ready <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_idx   <= w_idx_nxt;
                            tx_data <= w_byte_nxt;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_sequencer
// Brief    : Self-checking bench for step_sequencer with a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_step_sequencer;

    localparam int          F   = 5;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef STEP_SEQ_CHECKSUM_EN
    localparam int          NB  = 129;
`else
    localparam int          NB  = 128;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic          inst_ready;
    logic          proc_en;
    logic [31:0]   inst_out;
    logic [1023:0] regfile;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [15:0]   step_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit ready_mode = 1'b0;
    int cyc = 0;

    step_sequencer #(.FLUSH_CYCLES(F), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_ready(inst_ready), .proc_en(proc_en), .inst_out(inst_out),
        .regfile(regfile), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // tx_ready: always 1, or 1-of-3 cycles in stall mode
    always @(posedge clk) begin
        #2;
        tx_ready = ready_mode ? ((cyc % 3) == 0) : 1'b1;
        cyc++;
    end

    // ---------------- behavioural model: cycles counted since accept ----------------
    bit         m_active = 1'b0;
    bit         m_done   = 1'b0;
    int         m_k      = 0;
    int         m_sent   = 0;
    int         m_steps  = 0;
    logic [31:0] m_word  = 32'd0;
    logic [7:0] m_bytes [0:127];

    function automatic logic [7:0] m_byte(input int i);
        logic [7:0] x;
        if (i < 128) return m_bytes[i];
        x = 8'd0;
        for (int j = 0; j < 128; j++) x = x ^ m_bytes[j];
        return x;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0; m_done = 1'b0; m_steps = 0; m_sent = 0; m_k = 0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (inst_valid) begin
                    m_active = 1'b1; m_k = 1; m_word = inst_data; m_sent = 0;
                end
            end else begin
                // cycle k=1 issue, 2..F+1 flush, F+2 settle, F+3 snap, F+4.. send
                if (m_k == F + 3)
                    for (int j = 0; j < 128; j++) m_bytes[j] = regfile[8*j +: 8];
                if (m_k >= F + 4 && tx_ready) begin
                    m_sent++;
                    if (m_sent == NB) begin
                        m_active = 1'b0; m_done = 1'b1; m_steps = (m_steps + 1) & 16'hFFFF;
                    end
                end
                m_k++;
            end
        end
    end

    // ---------------- compare + monitor ----------------
    logic [7:0]  rx_q [$];
    int          pe_cnt, pe_runs, nop_cnt, done_cnt;
    bit          prev_pe;
    logic [31:0] first_inst;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("proc_en",    {31'd0, proc_en},    {31'd0, m_active && m_k >= 1 && m_k <= F + 1});
            chk("inst_out",   inst_out,            (m_active && m_k == 1) ? m_word : NOP);
            chk("tx_valid",   {31'd0, tx_valid},   {31'd0, m_active && m_k >= F + 4});
            chk("busy",       {31'd0, busy},       {31'd0, m_active});
            chk("inst_ready", {31'd0, inst_ready}, {31'd0, !m_active});
            chk("done",       {31'd0, done},       {31'd0, m_done});
            chk("step_count", {16'd0, step_count}, m_steps);
            if (m_active && m_k >= F + 4)
                chk("tx_data", {24'd0, tx_data}, {24'd0, m_byte(m_sent)});
        end
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (proc_en) begin
            if (pe_cnt == 0) first_inst = inst_out;
            else if (inst_out == NOP) nop_cnt++;
            pe_cnt++;
            if (!prev_pe) pe_runs++;
        end
        prev_pe = proc_en;
        if (done) done_cnt++;
    end

    task automatic clear_stats();
        rx_q.delete();
        pe_cnt = 0; pe_runs = 0; nop_cnt = 0; done_cnt = 0; prev_pe = 1'b0;
        first_inst = 32'd0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_step(input logic [31:0] word, input string name);
        inst_valid = 1'b1; inst_data = word;
        @(posedge clk); #2;
        inst_valid = 1'b0;
        wait_done(name);
        @(negedge clk); #1;
    endtask

    function automatic logic [1023:0] pattern(input int p);
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = 8'(i);
            r[32*i +: 32] = {8'(b * 8'd7 + 8'd1), b ^ 8'hA5, b + 8'h40, 8'(b * 8'd3)};
        end
        r[63:32] = 32'h00000005;
        return (p == 0) ? r : ~r;
    endfunction

    logic [1023:0] saved;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int errs;
        int n;
        reset = 1'b1; inst_valid = 1'b0; inst_data = 32'd0;
        regfile = pattern(0);
        clear_stats();
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("rst_tx_data",    {24'd0, tx_data},    32'd0);
        chk("rst_inst_out",   inst_out,            32'h00000013);
        chk("rst_step_count", {16'd0, step_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // step 1: addi x1,x0,5 with tx_ready high
        clear_stats();
        run_step(32'h00500093, "step1");
        chk("s1_pe_cnt",     pe_cnt,      32'd6);
        chk("s1_pe_runs",    pe_runs,     32'd1);
        chk("s1_first_inst", first_inst,  32'h00500093);
        chk("s1_nop_cnt",    nop_cnt,     32'd5);
        chk("s1_nbytes",     rx_q.size(), NB);
        chk("s1_byte4",      {24'd0, rx_q[4]}, 32'h05);
        chk("s1_byte5",      {24'd0, rx_q[5]}, 32'h00);
        chk("s1_byte6",      {24'd0, rx_q[6]}, 32'h00);
        chk("s1_byte7",      {24'd0, rx_q[7]}, 32'h00);
        chk("s1_done_cnt",   done_cnt,    32'd1);
        chk("s1_step_count", {16'd0, step_count}, 32'd1);

        // step 2: stalled tx, regfile changed and a new word held during SEND
        @(posedge clk); #2;
        clear_stats();
        saved = regfile;
        ready_mode = 1'b1;
        inst_valid = 1'b1; inst_data = 32'h00A00113;
        @(posedge clk); #2;
        inst_data = 32'h12345678;
        n = 0;
        while (!tx_valid && n < 100) begin @(posedge clk); #2; n++; end
        chk("s2_tx_start", {31'd0, tx_valid}, 32'd1);
        regfile = pattern(1);
        wait_done("step2");
        chk("s2_pe_cnt", pe_cnt, 32'd6);
        chk("s2_nbytes", rx_q.size(), NB);
        errs = 0;
        for (int k = 0; k < 128 && k < rx_q.size(); k++)
            if (rx_q[k] !== saved[8*k +: 8]) errs++;
        chk("s2_byte_errs", errs, 32'd0);
        @(posedge clk); #2;
        chk("s2_next_pe",   {31'd0, proc_en}, 32'd1);
        chk("s2_next_inst", inst_out, 32'h12345678);
        inst_valid = 1'b0;

        // step 3: reset mid-stream at byte 40
        ready_mode = 1'b0;
        rx_q.delete();
        n = 0;
        while (rx_q.size() < 40 && n < 500) begin @(posedge clk); #2; n++; end
        chk("s3_reached_40", {31'd0, rx_q.size() >= 40}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("s3_tx_valid",   {31'd0, tx_valid}, 32'd0);
        chk("s3_busy",       {31'd0, busy},     32'd0);
        chk("s3_step_count", {16'd0, step_count}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // step 4: full stream from byte 0 after reset
        regfile = pattern(0);
        clear_stats();
        run_step(32'h00100113, "step4");
        chk("s4_nbytes",     rx_q.size(), NB);
        chk("s4_byte0",      {24'd0, rx_q[0]},   {24'd0, regfile[7:0]});
        chk("s4_byte127",    {24'd0, rx_q[127]}, {24'd0, regfile[1023:1016]});
        chk("s4_step_count", {16'd0, step_count}, 32'd1);

        // checksum patterns
        @(posedge clk); #2;
        for (int i = 0; i < 32; i++) regfile[32*i +: 32] = 32'h01010101;
        clear_stats();
        run_step(32'h00000013, "step5");
        chk("s5_nbytes", rx_q.size(), NB);
`ifdef STEP_SEQ_CHECKSUM_EN
        chk("s5_checksum", {24'd0, rx_q[128]}, 32'h00);
`else
        chk("s5_byte127", {24'd0, rx_q[127]}, 32'h01);
`endif
        @(posedge clk); #2;
        regfile = '0;
        regfile[63:32] = 32'h000000FF;
        clear_stats();
        run_step(32'h00000013, "step6");
        chk("s6_nbytes", rx_q.size(), NB);
`ifdef STEP_SEQ_CHECKSUM_EN
        chk("s6_checksum", {24'd0, rx_q[128]}, 32'hFF);
`else
        chk("s6_byte4", {24'd0, rx_q[4]}, 32'hFF);
`endif
        chk("s6_step_count", {16'd0, step_count}, 32'd3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
